// File: rtl/snake_frame_fetcher.sv
// snake_frame_fetcher: streams the snake body table from dmem each frame and commits it atomically to snake_data.
module snake_frame_fetcher #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEGMENTS = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 12'd100
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_start,
  output logic [ADDR_WIDTH-1:0] address_dmem_fromVGA,
  output logic [DATA_WIDTH-1:0] data_fromVGA,
  output logic wren_fromVGA,
  input  logic [DATA_WIDTH-1:0] q_dmem_toVGA,
  output logic [NUM_SEGMENTS*DATA_WIDTH-1:0] snake_data,
  output logic snake_valid,
  output logic snake_update,
  output logic busy
);
  localparam int IDX_W = $clog2(NUM_SEGMENTS + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, COMMIT} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic pending;
  logic last, cap;
  logic [DATA_WIDTH-1:0] shadow [NUM_SEGMENTS];
  assign data_fromVGA = '0;
  assign wren_fromVGA = 1'b0;
  assign last = idx == IDX_W'(NUM_SEGMENTS - 1);
  // read data lags the address by one cycle, so the first READ cycle has nothing to capture
  assign cap = (state == READ && idx != '0) || state == DRAIN;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? (frame_start ? READ : IDLE) :
               (state == READ)  ? (last ? DRAIN : READ) :
               (state == DRAIN) ? COMMIT :
               ((pending || frame_start) ? READ : IDLE);
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      address_dmem_fromVGA <= BASE_ADDR;
      snake_data <= '0;
      snake_valid <= 1'b0;
      snake_update <= 1'b0;
      busy <= 1'b0;
      pending <= 1'b0;
      idx <= '0;
    end else begin
      busy <= state_nx != IDLE;
      snake_update <= state == COMMIT;
      if (state == COMMIT) begin
        snake_valid <= 1'b1;
        for (int j = 0; j < NUM_SEGMENTS; j++) snake_data[DATA_WIDTH*j +: DATA_WIDTH] <= shadow[j];
      end
      if (state == COMMIT) pending <= 1'b0;
      else if (state != IDLE && frame_start) pending <= 1'b1;
      if (state_nx == READ && state != READ) begin
        idx <= '0;
        address_dmem_fromVGA <= BASE_ADDR;
      end else if (state == READ && !last) begin
        idx <= idx + IDX_W'(1);
        address_dmem_fromVGA <= address_dmem_fromVGA + ADDR_WIDTH'(1);
      end
    end
  end
  // shift-in keeps segment order without a write index: after N captures word 0 sits at shadow[0]
  always_ff @(posedge clock) begin
    if (cap) begin
      for (int j = 0; j < NUM_SEGMENTS - 1; j++) shadow[j] <= shadow[j+1];
      shadow[NUM_SEGMENTS-1] <= q_dmem_toVGA;
    end
  end
endmodule

// File: tb/tb_snake_frame_fetcher.sv
// tb_snake_frame_fetcher: randomized checks of two fetchers (default base and wrapping base) against a table model.
module tb_snake_frame_fetcher;
  localparam int N = 10, DW = 32, AW = 12;
  logic clock = 0, reset = 1, frame_start = 0;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] d1, d2, q1, q2;
  logic w1, w2, v1, v2, u1, u2, b1, b2;
  logic [N*DW-1:0] sd1, sd2;
  logic [DW-1:0] mem [4096];
  int compared = 0, mismatched = 0, const_bad = 0;
  logic [AW-1:0] tr_a1 [64], tr_a2 [64];
  logic tr_b [64], tr_u [64], tr_v [64];
  logic [N*DW-1:0] tr_d [64], tr_d2 [64];
  always #5 clock = ~clock;
  always @(posedge clock) begin
    q1 <= mem[a1];
    q2 <= mem[a2];
  end
  always @(negedge clock) if (w1 !== 1'b0 || w2 !== 1'b0 || d1 !== '0 || d2 !== '0) const_bad++;
  snake_frame_fetcher dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .address_dmem_fromVGA(a1), .data_fromVGA(d1), .wren_fromVGA(w1), .q_dmem_toVGA(q1),
    .snake_data(sd1), .snake_valid(v1), .snake_update(u1), .busy(b1));
  snake_frame_fetcher #(.BASE_ADDR(12'd4090)) dut_w (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .address_dmem_fromVGA(a2), .data_fromVGA(d2), .wren_fromVGA(w2), .q_dmem_toVGA(q2),
    .snake_data(sd2), .snake_valid(v2), .snake_update(u2), .busy(b2));

  function automatic logic [N*DW-1:0] table_at(input int base);
    logic [N*DW-1:0] t;
    for (int i = 0; i < N; i++) t[DW*i +: DW] = mem[(base + i) % 4096];
    return t;
  endfunction

  // frame_start pulses at relative edge 0 (and p2/p3); reset at edge prst; trace slot c is cycle k+c
  task automatic run(input int ncyc, input int p2, input int p3, input int prst);
    frame_start = 1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clock);
      tr_a1[c] = a1; tr_a2[c] = a2; tr_b[c] = b1; tr_u[c] = u1; tr_v[c] = v1;
      tr_d[c] = sd1; tr_d2[c] = sd2;
      frame_start = (c == p2) || (c == p3);
      reset = (c == prst);
    end
    frame_start = 0;
    reset = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    compared++; if (a1 !== 12'd100) begin mismatched++; $display("FAIL reset_addr: got %0d want 100", a1); end
    compared++; if (a2 !== 12'd4090) begin mismatched++; $display("FAIL reset_addr_w: got %0d want 4090", a2); end
    compared++; if (sd1 !== '0) begin mismatched++; $display("FAIL reset_data: got %h want 0", sd1); end
    compared++; if ({v1, u1, b1} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b want 000", {v1, u1, b1}); end
  endtask

  task automatic test_single_fetch;
    for (int i = 0; i < N; i++) mem[100 + i] = 3 * i + 1;
    run(N + 4, 0, 0, 0);
    for (int c = 1; c <= N; c++) begin
      compared++; if (tr_a1[c] !== AW'(100 + c - 1)) begin mismatched++; $display("FAIL single_addr c=%0d: got %0d want %0d", c, tr_a1[c], 100 + c - 1); end
    end
    for (int c = 1; c <= N + 2; c++) begin
      compared++; if (tr_b[c] !== 1'b1) begin mismatched++; $display("FAIL single_busy c=%0d: got %b want 1", c, tr_b[c]); end
    end
    compared++; if (tr_b[N+3] !== 1'b0) begin mismatched++; $display("FAIL single_busy_end: got %b want 0", tr_b[N+3]); end
    compared++; if ({tr_u[N+2], tr_u[N+3], tr_u[N+4]} !== 3'b010) begin mismatched++; $display("FAIL single_update: got %b want 010", {tr_u[N+2], tr_u[N+3], tr_u[N+4]}); end
    compared++; if ({tr_v[N+2], tr_v[N+3]} !== 2'b01) begin mismatched++; $display("FAIL single_valid: got %b want 01", {tr_v[N+2], tr_v[N+3]}); end
    compared++; if (tr_d[N+2] !== '0) begin mismatched++; $display("FAIL single_precommit: got %h want 0", tr_d[N+2]); end
    compared++; if (tr_d[N+3][31:0] !== 32'd1 || tr_d[N+3][319:288] !== 32'd28) begin mismatched++; $display("FAIL single_ends: got %0d/%0d want 1/28", tr_d[N+3][31:0], tr_d[N+3][319:288]); end
    compared++; if (tr_d[N+3] !== table_at(100)) begin mismatched++; $display("FAIL single_table: got %h want %h", tr_d[N+3], table_at(100)); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    run(2 * N + 6, 4, 6, 0);
    for (int c = 1; c <= 2 * N + 6; c++) n += int'(tr_u[c]);
    compared++; if (n !== 2) begin mismatched++; $display("FAIL b2b_updates: got %0d want 2", n); end
    compared++; if (tr_u[N+3] !== 1'b1 || tr_u[2*N+5] !== 1'b1) begin mismatched++; $display("FAIL b2b_update_pos: got %b%b want 11", tr_u[N+3], tr_u[2*N+5]); end
    for (int c = N + 3; c <= 2 * N + 2; c++) begin
      compared++; if (tr_a1[c] !== AW'(100 + c - N - 3)) begin mismatched++; $display("FAIL b2b_addr c=%0d: got %0d want %0d", c, tr_a1[c], 100 + c - N - 3); end
    end
    for (int c = 1; c <= 2 * N + 4; c++) begin
      compared++; if (tr_b[c] !== 1'b1) begin mismatched++; $display("FAIL b2b_busy c=%0d: got %b want 1", c, tr_b[c]); end
    end
    compared++; if (tr_b[2*N+5] !== 1'b0 || tr_b[2*N+6] !== 1'b0) begin mismatched++; $display("FAIL b2b_third: got %b%b want 00", tr_b[2*N+5], tr_b[2*N+6]); end
  endtask

  task automatic test_commit_pulse;
    int n = 0;
    run(2 * N + 6, N + 2, 0, 0);
    for (int c = 1; c <= 2 * N + 6; c++) n += int'(tr_u[c]);
    compared++; if (n !== 2) begin mismatched++; $display("FAIL commit_pulse_updates: got %0d want 2", n); end
    compared++; if (tr_a1[N+3] !== AW'(100) || tr_b[N+3] !== 1'b1) begin mismatched++; $display("FAIL commit_pulse_restart: got addr %0d busy %b want 100 1", tr_a1[N+3], tr_b[N+3]); end
  endtask

  task automatic test_word_update;
    logic [N*DW-1:0] prev;
    @(negedge clock);
    prev = sd1;
    mem[105] = 77;
    run(N + 4, 0, 0, 0);
    compared++; if (tr_d[N+3][191:160] !== 32'd77) begin mismatched++; $display("FAIL word5: got %0d want 77", tr_d[N+3][191:160]); end
    for (int i = 0; i < N; i++) if (i != 5) begin
      compared++; if (tr_d[N+3][DW*i +: DW] !== prev[DW*i +: DW]) begin mismatched++; $display("FAIL word_keep i=%0d: got %h want %h", i, tr_d[N+3][DW*i +: DW], prev[DW*i +: DW]); end
    end
  endtask

  task automatic test_reset_mid_fetch;
    int n = 0;
    run(N + 6, 0, 0, 5);
    compared++; if (tr_b[5] !== 1'b1) begin mismatched++; $display("FAIL midrst_busy_before: got %b want 1", tr_b[5]); end
    compared++; if ({tr_b[6], tr_v[6], tr_u[6]} !== 3'b000) begin mismatched++; $display("FAIL midrst_flags: got %b want 000", {tr_b[6], tr_v[6], tr_u[6]}); end
    compared++; if (tr_d[6] !== '0 || tr_a1[6] !== AW'(100)) begin mismatched++; $display("FAIL midrst_state: got addr %0d data %h want 100 0", tr_a1[6], tr_d[6]); end
    for (int c = 6; c <= N + 6; c++) n += int'(tr_u[c]) + int'(tr_b[c]) + int'(tr_v[c]);
    compared++; if (n !== 0) begin mismatched++; $display("FAIL midrst_quiet: got %0d active flags want 0", n); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < N; i++) mem[(4090 + i) % 4096] = $urandom;
    run(N + 4, 0, 0, 0);
    for (int c = 1; c <= N; c++) begin
      compared++; if (tr_a2[c] !== AW'((4090 + c - 1) % 4096)) begin mismatched++; $display("FAIL wrap_addr c=%0d: got %0d want %0d", c, tr_a2[c], (4090 + c - 1) % 4096); end
    end
    compared++; if (tr_d2[N+3][223:192] !== mem[0]) begin mismatched++; $display("FAIL wrap_seg6: got %h want %h", tr_d2[N+3][223:192], mem[0]); end
    compared++; if (tr_d2[N+3] !== table_at(4090)) begin mismatched++; $display("FAIL wrap_table: got %h want %h", tr_d2[N+3], table_at(4090)); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int p2, n;
      for (int i = 0; i < N; i++) begin
        mem[100 + i] = $urandom;
        mem[(4090 + i) % 4096] = $urandom;
      end
      p2 = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, N + 2));
      repeat ($urandom_range(0, 4)) @(negedge clock);
      run(2 * N + 6, p2, 0, 0);
      n = 0;
      for (int c = 1; c <= 2 * N + 6; c++) n += int'(tr_u[c]);
      compared++; if (n !== (p2 != 0 ? 2 : 1)) begin mismatched++; $display("FAIL rand_updates it=%0d: got %0d want %0d", it, n, p2 != 0 ? 2 : 1); end
      compared++; if (tr_d[2*N+6] !== table_at(100)) begin mismatched++; $display("FAIL rand_table it=%0d: got %h want %h", it, tr_d[2*N+6], table_at(100)); end
      compared++; if (tr_d2[2*N+6] !== table_at(4090)) begin mismatched++; $display("FAIL rand_table_w it=%0d: got %h want %h", it, tr_d2[2*N+6], table_at(4090)); end
      compared++; if (tr_v[2*N+6] !== 1'b1 || tr_b[2*N+6] !== 1'b0) begin mismatched++; $display("FAIL rand_idle it=%0d: got valid %b busy %b want 1 0", it, tr_v[2*N+6], tr_b[2*N+6]); end
    end
  endtask

  task automatic test_const_outputs;
    compared++; if (const_bad !== 0) begin mismatched++; $display("FAIL const_outputs: got %0d bad cycles want 0", const_bad); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_commit_pulse();
    test_word_update();
    test_reset_mid_fetch();
    test_wrap();
    test_random();
    test_const_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
